// File: rtl/adc_frame_tx.sv
// Decimating ADC sampler that packs FRAME_LEN samples into a framed byte stream:
// sync byte, sequence number, samples, 8-bit wrapping checksum.
module adc_frame_tx #(
  parameter int unsigned DECIM     = 4,
  parameter int unsigned FRAME_LEN = 8,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] adin_data,
  input  logic       tx_ready,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       frame_active,
  output logic       overrun
);

  localparam int unsigned DCW   = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int unsigned IW    = $clog2(FRAME_LEN + 3);
  localparam int unsigned AW    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned DEPTH = 1 << AW;

  localparam logic [DCW-1:0] DCNT_LAST = DCW'(DECIM - 1);
  localparam logic [IW-1:0]  WIDX_FULL = IW'(FRAME_LEN);
  localparam logic [IW-1:0]  BIDX_LAST = IW'(FRAME_LEN + 2);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [DCW-1:0] dcnt_q, dcnt_d;
  logic [IW-1:0]  widx_q, widx_d;
  logic [IW-1:0]  bidx_q, bidx_d;
  logic [IW-1:0]  widx_inc;
  logic [7:0]     seq_q, seq_d;
  logic [7:0]     csum_q, csum_d;
  logic [7:0]     seq_inc;
  logic           ovr_q, ovr_d;
  logic           strobe;
  logic           buf_we;
  logic [AW-1:0]  wr_addr;
  logic [AW-1:0]  rd_addr;
  logic [7:0]     byte_sel;
  logic [7:0]     buf_q [DEPTH];

  // Byte order on the wire: sync, seq, samples, checksum.
  function automatic logic [7:0] pick_byte(input logic [IW-1:0] idx,
                                           input logic [7:0]    seq,
                                           input logic [7:0]    csum,
                                           input logic [7:0]    sample);
    if (idx == '0)
      return SYNC_BYTE;
    else if (idx == IW'(1))
      return seq;
    else if (idx == BIDX_LAST)
      return csum;
    else
      return sample;
  endfunction

  always_comb begin
    strobe = enable && (dcnt_q == DCNT_LAST);
    if (!enable || strobe)
      dcnt_d = '0;
    else
      dcnt_d = dcnt_q + 1'b1;
  end

  always_comb begin
    widx_inc = widx_q + 1'b1;
    seq_inc  = seq_q + 8'd1;
    wr_addr  = AW'(widx_q);
    rd_addr  = AW'(bidx_q - IW'(2));
    byte_sel = pick_byte(bidx_q, seq_q, csum_q, buf_q[rd_addr]);
  end

  always_comb begin
    state_d      = state_q;
    widx_d       = widx_q;
    bidx_d       = bidx_q;
    seq_d        = seq_q;
    csum_d       = csum_q;
    ovr_d        = ovr_q;
    buf_we       = 1'b0;
    tx_start     = 1'b0;
    frame_active = 1'b0;
    case (state_q)
      FILL: begin
        // Dropping enable throws away a partial frame, checksum included.
        if (!enable) begin
          widx_d = '0;
          csum_d = seq_q;
        end else if (strobe) begin
          buf_we = 1'b1;
          widx_d = widx_inc;
          csum_d = csum_q + adin_data;
          if (widx_inc == WIDX_FULL) begin
            state_d = SEND;
            bidx_d  = '0;
          end
        end
      end
      SEND: begin
        frame_active = 1'b1;
        if (strobe)
          ovr_d = 1'b1;
        if (tx_ready) begin
          tx_start = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        frame_active = 1'b1;
        if (strobe)
          ovr_d = 1'b1;
        // The transmitter must show busy before the next byte may launch.
        if (!tx_ready) begin
          if (bidx_q == BIDX_LAST) begin
            state_d = FILL;
            seq_d   = seq_inc;
            widx_d  = '0;
            csum_d  = seq_inc;
          end else begin
            bidx_d  = bidx_q + 1'b1;
            state_d = SEND;
          end
        end
      end
      default: state_d = FILL;
    endcase
    tx_data = frame_active ? byte_sel : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      dcnt_q  <= '0;
      widx_q  <= '0;
      bidx_q  <= '0;
      seq_q   <= '0;
      csum_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      widx_q  <= widx_d;
      bidx_q  <= bidx_d;
      seq_q   <= seq_d;
      csum_q  <= csum_d;
      ovr_q   <= ovr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we)
      buf_q[wr_addr] <= adin_data;
  end

  assign overrun = ovr_q;

endmodule

// File: tb/tb_adc_frame_tx.sv
// Directed bench for adc_frame_tx: a transmitter model logs launched bytes,
// frames are compared against hand-computed byte sequences.
module tb_adc_frame_tx;

  localparam int FRAME_LEN = 8;
  localparam int DECIM     = 4;
  localparam int NBYTES    = FRAME_LEN + 3;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [7:0] adin_data;
  logic       tx_ready;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       frame_active;
  logic       overrun;

  int nchk = 0;
  int nerr = 0;

  logic [7:0] got_q [$];
  int busy_len  = 10;
  int long_idx  = -1;
  int long_busy = 40;

  typedef struct {
    logic [7:0] adin;
    logic [7:0] seq;
    logic [7:0] csum;
  } fvec_t;

  fvec_t tbl [5];

  adc_frame_tx #(
    .DECIM    (DECIM),
    .FRAME_LEN(FRAME_LEN),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .adin_data   (adin_data),
    .tx_ready    (tx_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .frame_active(frame_active),
    .overrun     (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", nchk, nerr);
    $fatal(1, "watchdog");
  end

  // Transmitter: ready drops the cycle after a launch and stays low for busy cycles.
  initial begin
    int busy;
    bit arm;
    int arm_idx;
    busy = 0;
    arm = 1'b0;
    arm_idx = 0;
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (busy > 0) begin
        busy--;
        if (busy == 0)
          tx_ready = 1'b1;
      end else if (arm) begin
        arm = 1'b0;
        tx_ready = 1'b0;
        busy = (arm_idx == long_idx) ? long_busy : busy_len;
      end
      @(negedge clk);
      if (tx_start === 1'b1) begin
        got_q.push_back(tx_data);
        arm = 1'b1;
        arm_idx = got_q.size() - 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gb(input int i);
    if (i >= 0 && i < got_q.size())
      return got_q[i];
    return 8'hxx;
  endfunction

  task automatic do_reset(input string nm);
    reset = 1'b1;
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({nm, " tx_start"}, {31'd0, tx_start}, 32'd0);
    chk({nm, " tx_data"}, {24'd0, tx_data}, 32'd0);
    chk({nm, " frame_active"}, {31'd0, frame_active}, 32'd0);
    chk({nm, " overrun"}, {31'd0, overrun}, 32'd0);
    reset = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int cnt;
    cnt = 0;
    while (frame_active !== 1'b0 && cnt < 4000) begin
      @(negedge clk);
      cnt++;
    end
    if (frame_active !== 1'b0)
      chk({nm, " frame end timeout"}, {31'd0, frame_active}, 32'd0);
  endtask

  task automatic run_frame(input string nm, input logic [7:0] d, input bit gate,
                           output int base, output int lat, output logic ts0);
    base = got_q.size();
    adin_data = d;
    enable = 1'b1;
    lat = 0;
    while (frame_active !== 1'b1 && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    ts0 = tx_start;
    if (frame_active !== 1'b1)
      chk({nm, " frame start timeout"}, {31'd0, frame_active}, 32'd1);
    if (gate)
      enable = 1'b0;
    wait_idle(nm);
  endtask

  task automatic check_frame(input string nm, input int base, input logic [7:0] seq,
                             input logic [7:0] d, input logic [7:0] cs);
    logic [7:0] exp;
    chk({nm, " count"}, got_q.size() - base, NBYTES);
    for (int i = 0; i < NBYTES; i++) begin
      if (i == 0)
        exp = 8'hA5;
      else if (i == 1)
        exp = seq;
      else if (i == NBYTES - 1)
        exp = cs;
      else
        exp = d;
      chk($sformatf("%s byte%0d", nm, i), {24'd0, gb(base + i)}, {24'd0, exp});
    end
  endtask

  initial begin
    int base;
    int lat;
    int cnt;
    int seen;
    logic ts0;
    bit ovr_seen;

    tbl[0] = '{adin: 8'h10, seq: 8'h00, csum: 8'h80};
    tbl[1] = '{adin: 8'hF0, seq: 8'h01, csum: 8'h81};
    tbl[2] = '{adin: 8'h01, seq: 8'h02, csum: 8'h0A};
    tbl[3] = '{adin: 8'hFF, seq: 8'h03, csum: 8'hFB};
    tbl[4] = '{adin: 8'h5A, seq: 8'h04, csum: 8'hD4};

    reset = 1'b1;
    enable = 1'b0;
    adin_data = 8'h00;
    do_reset("reset0");

    for (int i = 0; i < 5; i++) begin
      run_frame($sformatf("tbl%0d", i), tbl[i].adin, 1'b1, base, lat, ts0);
      chk($sformatf("tbl%0d latency", i), lat, 32);
      chk($sformatf("tbl%0d first tx_start", i), {31'd0, ts0}, 32'd1);
      check_frame($sformatf("tbl%0d", i), base, tbl[i].seq, tbl[i].adin, tbl[i].csum);
      chk($sformatf("tbl%0d overrun", i), {31'd0, overrun}, 32'd0);
    end

    // Overrun: first byte holds the transmitter busy for 40 cycles, enable stays high.
    do_reset("reset_ovr");
    long_idx = got_q.size();
    base = got_q.size();
    adin_data = 8'h33;
    enable = 1'b1;
    lat = 0;
    while (frame_active !== 1'b1 && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    chk("ovr latency", lat, 32);
    chk("ovr clear at start", {31'd0, overrun}, 32'd0);
    ovr_seen = 1'b0;
    for (int k = 0; k < DECIM; k++) begin
      @(negedge clk);
      if (overrun === 1'b1)
        ovr_seen = 1'b1;
    end
    chk("ovr set within DECIM", {31'd0, ovr_seen}, 32'd1);
    wait_idle("ovr");
    check_frame("ovr", base, 8'h00, 8'h33, 8'h98);
    chk("ovr sticky end", {31'd0, overrun}, 32'd1);
    repeat (20) @(negedge clk);
    chk("ovr sticky later", {31'd0, overrun}, 32'd1);
    long_idx = -1;
    do_reset("reset_ovr_clr");

    // Partial discard: three samples of 11, two idle cycles, then a fresh frame of 22.
    adin_data = 8'h11;
    enable = 1'b1;
    repeat (12) @(negedge clk);
    chk("partial no frame yet", {31'd0, frame_active}, 32'd0);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    run_frame("partial", 8'h22, 1'b1, base, lat, ts0);
    chk("partial latency", lat, 32);
    check_frame("partial", base, 8'h00, 8'h22, 8'h10);

    // Mid-frame reset right as byte 4 launches.
    do_reset("reset_mid_pre");
    adin_data = 8'h44;
    enable = 1'b1;
    seen = 0;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      if (tx_start === 1'b1)
        seen++;
    end while (seen < 5 && cnt < 3000);
    chk("midrst reached byte4", seen, 5);
    reset = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    chk("midrst tx_start", {31'd0, tx_start}, 32'd0);
    chk("midrst frame_active", {31'd0, frame_active}, 32'd0);
    chk("midrst tx_data", {24'd0, tx_data}, 32'd0);
    chk("midrst overrun", {31'd0, overrun}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    run_frame("midrst next", 8'h55, 1'b1, base, lat, ts0);
    chk("midrst next latency", lat, 32);
    check_frame("midrst next", base, 8'h00, 8'h55, 8'hA8);

    // Sequence wrap over 257 frames with a fast transmitter.
    do_reset("reset_wrap");
    busy_len = 1;
    for (int f = 0; f < 257; f++) begin
      run_frame($sformatf("wrap f%0d", f), 8'h01, 1'b1, base, lat, ts0);
      chk($sformatf("wrap seq f%0d", f), {24'd0, gb(base + 1)}, {24'd0, 8'(f)});
      chk($sformatf("wrap csum f%0d", f), {24'd0, gb(base + NBYTES - 1)}, {24'd0, 8'(f + 8)});
      if (f == 256)
        check_frame("wrap f256", base, 8'h00, 8'h01, 8'h08);
    end
    chk("wrap overrun", {31'd0, overrun}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/adc_frame_tx.md
ADC_FRAME_TX -- requirements
Module: adc_frame_tx

Interface
REQ-001 Parameter DECIM, default 4: one ADC sample is captured every DECIM clocks (legal range 1..256).
REQ-002 Parameter FRAME_LEN, default 8: samples per frame (legal range 1..64).
REQ-003 Parameter SYNC_BYTE, default 8'hA5: first byte of every frame.
REQ-004 Port list, one port per line:
- clk  input  1  system clock (internal HFOSC domain).
- reset  input  1  synchronous, active-high reset.
- enable  input  1  capture enable.
- adin_data  input  8  ADC sample bus, sampled on the clk rising edge.
- tx_ready  input  1  byte transmitter idle/ready.
- tx_start  output  1  one-cycle byte launch strobe to the transmitter.
- tx_data  output  8  byte to transmit; valid while tx_start=1.
- frame_active  output  1  high while a frame is being transmitted.
- overrun  output  1  sticky flag: a sample was dropped.
REQ-005 One clock domain only; reset is synchronous and active-high; no other clocks and no asynchronous logic.

Function
REQ-006 Three states: FILL, SEND, WAIT.
REQ-007 Decimation counter dcnt, 0..DECIM-1:
- Counts while enable=1, in any state.
- Capture strobe fires when dcnt==DECIM-1; dcnt then wraps to 0.
- enable=0 holds dcnt at 0.
REQ-008 FILL, on a strobe: adin_data is written to buf[widx] and widx increments.
- When the write makes widx==FRAME_LEN, the next state is SEND and bidx=0.
REQ-009 FILL, enable=0: widx clears to 0, so any partial frame is discarded.
REQ-010 Frame byte order is SYNC_BYTE, seq, buf[0]..buf[FRAME_LEN-1], csum, for FRAME_LEN+3 bytes in total.
REQ-011 csum = (seq + sum of buf[i]) mod 256. It is 8-bit wrapping, accumulated during FILL, and seeded with seq at frame start.
REQ-012 SEND, tx_ready=1: tx_start=1 for exactly one cycle, tx_data = byte[bidx], and the next state is WAIT.
- SEND with tx_ready=0 waits with tx_start=0.
REQ-013 WAIT holds tx_data stable.
- On the first cycle with tx_ready=0: if bidx is the last byte, the next state is FILL; otherwise bidx increments and the next state is SEND.
REQ-014 Transmitter ready deassertion:
- The transmitter deasserts tx_ready 1 or more cycles after tx_start.
- tx_start is never reissued before tx_ready has been observed low.
REQ-015 End of frame (WAIT to FILL transition):
- seq increments with wrap 8'hFF to 8'h00.
- widx clears to 0.
- csum reseeds to the new seq.
REQ-016 A capture strobe in SEND or WAIT drops its sample, does not write buf, and sets overrun=1. overrun stays set until reset.
REQ-017 frame_active=1 exactly when the state is SEND or WAIT.
REQ-018 enable=0 during SEND or WAIT does not abort the frame; it completes.
REQ-019 Latency: the first tx_start occurs 1 cycle after the strobe that captured the last sample, given tx_ready=1.

Reset
REQ-020 reset=1 at a clock edge takes effect on that edge, in any state, and resets:
- state=FILL, dcnt=0, widx=0, bidx=0, seq=0, csum=0
- tx_start=0, tx_data=8'h00, frame_active=0, overrun=0
REQ-021 Reset mid-frame abandons the frame; no further tx_start is issued until a new full frame has been captured.
REQ-022 buf contents are not reset and are don't-care.

Verification
REQ-023 Basic frame:
- Stimulus: defaults, enable=1, adin_data=8'h10 constant, tx_ready modelled as low for 10 cycles after each tx_start.
- Required: bytes A5,00,10,10,10,10,10,10,10,10,80; overrun=0.
REQ-024 Checksum wrap and sequence:
- Stimulus: adin_data=8'hF0 held over the second frame.
- Required: second frame is A5,01,F0x8,81 (csum = 01 + 8×F0 = 0x781, kept as 0x81).
REQ-025 Overrun:
- Stimulus: tx_ready held low for 40 cycles after the first tx_start.
- Required: overrun=1 within the next DECIM cycles; frame bytes unchanged; overrun stays 1 until reset.
REQ-026 Partial discard:
- Stimulus: enable=1 for 3 strobes, enable=0 for 2 cycles, then enable=1.
- Required: the next frame holds only post-re-enable samples; the first tx_start occurs after 8 further strobes.
REQ-027 Mid-frame reset:
- Stimulus: reset=1 for 1 cycle at bidx=4.
- Required: next cycle tx_start=0 and frame_active=0; the next frame starts A5,00.
REQ-028 Seq wrap:
- Stimulus: run 257 frames.
- Required: frame 256 (zero-based) carries seq 00 again.
